// File: rtl/fetch_unit_tr.sv
// Instruction fetch stage: PC, synchronous-read instruction memory and a show-ahead prefetch FIFO.
// Define FETCH_HALT_MARKER_EN to make 32'hFFFF_FFFF an end marker that halts fetching.
module fetch_unit_tr #(
   parameter int          ADDR_W     = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fetch_en,
   input  logic                          redirect,
   input  logic [ADDR_W-1:0]             redirect_pc,
   output logic [31:0]                   instr,
   output logic [ADDR_W-1:0]             instr_pc,
   output logic                          instr_valid,
   input  logic                          instr_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          halted
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]       MEM [0:(2**ADDR_W)-1];

   logic [ADDR_W-1:0] pc_q, rd_pc_q;
   logic [31:0]       rd_q;
   logic              infl_q;
   logic [31:0]       fdat_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fpc_q  [FIFO_DEPTH];
   logic [PW-1:0]     head_q, tail_q;
   logic [CW-1:0]     cnt_q;
   logic [31:0]       last_instr_q;
   logic [ADDR_W-1:0] last_pc_q;
   logic              marker, halted_w, iss, push, pop, not_empty;
   logic [CW:0]       used;

`ifdef FETCH_HALT_MARKER_EN
   logic halted_q;
   assign marker   = infl_q && (rd_q == 32'hFFFF_FFFF);
   assign halted_w = halted_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           halted_q <= 1'b0;
      else if (redirect) halted_q <= 1'b0;
      else if (marker)   halted_q <= 1'b1;
   end
`else
   assign marker   = 1'b0;
   assign halted_w = 1'b0;
`endif

   // Credits include the read in flight so a push can never find the FIFO full.
   assign used      = {1'b0, cnt_q} + (CW+1)'(infl_q);
   assign not_empty = (cnt_q != '0);
   assign iss       = fetch_en && !redirect && !halted_w && !marker
                      && (used < (CW+1)'(FIFO_DEPTH));
   assign push      = infl_q && !redirect && !marker;
   assign pop       = not_empty && instr_ready && !redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= ADDR_W'(RESET_PC);
         rd_pc_q <= '0;
         infl_q  <= 1'b0;
      end else begin
         infl_q <= iss;
         if (iss) rd_pc_q <= pc_q;
         if (redirect)    pc_q <= redirect_pc;
         else if (marker) pc_q <= rd_pc_q;
         else if (iss)    pc_q <= pc_q + ADDR_W'(1);
      end
   end

   // Memory array and data storage carry no reset so they map onto RAM.
   always_ff @(posedge clk) begin
      if (iss) rd_q <= MEM[pc_q];
      if (push) begin
         fdat_q[tail_q] <= rd_q;
         fpc_q[tail_q]  <= rd_pc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else if (redirect) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) tail_q <= tail_q + PW'(1);
         if (pop)  head_q <= head_q + PW'(1);
         if (push && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
   end

   // Remembers the head on display so the outputs hold once the FIFO empties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_instr_q <= '0;
         last_pc_q    <= '0;
      end else if (not_empty) begin
         last_instr_q <= fdat_q[head_q];
         last_pc_q    <= fpc_q[head_q];
      end
   end

   assign instr       = not_empty ? fdat_q[head_q] : last_instr_q;
   assign instr_pc    = not_empty ? fpc_q[head_q]  : last_pc_q;
   assign instr_valid = not_empty;
   assign fifo_count  = cnt_q;
   assign halted      = halted_w;
endmodule
